mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Shares one 8x8 decoder-based multiplier core among NREQ requesters.
- The core is the team's existing combinational multiplier module `main` (ports B, A, PO; 20-bit product).
- Round-robin arbitration, valid/ready handshake on every requester, one registered response channel tagged with the requester ID.
- Low-power operand isolation: the core's inputs are held at zero whenever no operation is in flight, so the core does not toggle while idle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; fixed by the core and must equal 8.
- PW, 20, product/response width; matches the core output PO.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_a  input  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  input  NREQ*W  packed operand B; requester i uses bits [i*W +: W].
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  downstream accepts the product.
- rsp_data  output  PW  registered product, zero-extended A*B.
- rsp_id  output  IDW  index of the requester that owns rsp_data.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, operand registers=0, state=IDLE, rr_ptr=NREQ-1.
- The async rst aborts any operation in flight; the in-flight result is discarded and never presented.
- FSM states are IDLE, CALC and HOLD.
- IDLE:
  - grant = first i with req_valid[i]=1, searching (rr_ptr+1) mod NREQ upward with wrap.
  - req_ready[grant]=1 combinationally. This is the only path where req_ready depends on req_valid.
  - On the handshake: latch A and B into the operand registers, latch id, set rr_ptr=grant, go to CALC.
  - No valid request: stay in IDLE with req_ready=0.
- CALC:
  - The core settles from the operand registers.
  - At the end of the cycle: rsp_data<=PO, rsp_id<=id, rsp_valid<=1, operand registers<=0 (isolation), go to HOLD.
- HOLD:
  - rsp_valid=1; rsp_data and rsp_id stay stable until rsp_ready=1.
  - On the handshake: rsp_valid<=0, go to IDLE.
  - No request is accepted in the handshake cycle.
- Latency: request handshake at cycle t gives rsp_valid at t+2. Minimum issue interval is 3 cycles.
- req_ready is 0 in CALC and HOLD. A requester must hold req_valid and its operands stable until accepted; a request dropped before acceptance is simply never served.
- Fairness: after requester i is served, i has the lowest priority. rr_ptr changes only on an accept.
- Arithmetic: unsigned, PO = A*B. Maximum 255*255 = 65025, so bits [19:16] of rsp_data are always 0.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if the accepted A==0 or B==0, skip CALC and go directly to HOLD.
  - rsp_data=0, latency t+1, operand registers stay 0 so the core never toggles.
  - Nonzero operands behave as the baseline.
- Undefined: every operation goes through CALC (latency t+2).

Decomposition:
- Package mul_share_pkg:
  - state enum {IDLE, CALC, HOLD};
  - localparams W=8 and PW=20;
  - function rr_pick(valid, ptr) returning the grant index and a found flag.
- One sub-module: mul_rr_arb, a combinational round-robin picker (inputs valid and ptr; outputs grant one-hot, grant index, any).
- The FSM, operand registers and the `main` instance live in mul_share_arb.

Test Plan:
- Reset then a single request: req_valid=0001, A=8'd13, B=8'd11 -> req_ready=0001 in the same cycle; rsp_valid at t+2 with rsp_data=143, rsp_id=0.
- Maximum operands: A=255, B=255 from requester 3 -> rsp_data=20'd65025, rsp_id=3.
- Round-robin:
  - Stimulus: req_valid=1111 held, rsp_ready=1, each requester reissuing.
  - Required: grant order 0,1,2,3,0.
  - Required: each response's rsp_id matches its grant and rsp_data matches that requester's A*B.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data and rsp_id stable, req_ready=0 throughout; accepting resumes the cycle after rsp_ready=1.
- Reset mid-operation: assert rst in CALC -> rsp_valid=0 immediately, no stale response after release; the next grant goes to requester 0 when all are valid.
- Zero operand (A=0, B=200):
  - With MUL_ZERO_SKIP_EN: rsp_valid at t+1, rsp_data=0.
  - Without it: rsp_valid at t+2, rsp_data=0.
  - In both builds the operand registers read 0 in IDLE and HOLD.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types, widths and the round-robin pick function for the shared
// multiplier arbiter.
package mul_share_pkg;

    localparam int unsigned W      = 8;
    localparam int unsigned PW     = 20;
    localparam int unsigned MAXREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Round-robin search starting one past ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [7:0]  valid,
                                         input logic [2:0]  ptr,
                                         input int unsigned nreq);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 1; k <= MAXREQ; k++) begin
            if (k <= nreq) begin
                cand = (32'(ptr) + k) % nreq;
                if (!r.found && valid[cand[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = cand[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/main.sv
// Combinational 8x8 unsigned multiplier built from radix-4 digit decoders;
// each 2-bit digit of B selects 0, A, 2A or 3A as a partial product.
module main (
    input  logic [7:0]  B,
    input  logic [7:0]  A,
    output logic [19:0] PO
);

    logic [19:0] pp;

    always_comb begin
        PO = '0;
        pp = '0;
        for (int i = 0; i < 4; i++) begin
            case (B[2*i +: 2])
                2'd0:    pp = '0;
                2'd1:    pp = 20'(A);
                2'd2:    pp = 20'(A) << 1;
                default: pp = 20'(A) + (20'(A) << 1);
            endcase
            PO = PO + (pp << (2 * i));
        end
    end

endmodule

// File: rtl/mul_rr_arb.sv
// Combinational round-robin picker: highest priority is the requester just
// after ptr.
module mul_rr_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    rr_pick_t pick;

    always_comb begin
        pick      = rr_pick(8'(valid), 3'(ptr), NREQ);
        any       = pick.found;
        grant_idx = IDW'(pick.idx);
        grant     = '0;
        if (pick.found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one 8x8 multiplier core with operand isolation.
// Optional MUL_ZERO_SKIP_EN: zero operands bypass CALC and respond a cycle early.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PW-1:0]     rsp_data,
    output logic [IDW-1:0]    rsp_id
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any;
    logic            accept;
    logic            zero_op;
    logic [W-1:0]    acc_a, acc_b;
    logic [PW-1:0]   core_po;

    mul_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Core sees only the operand registers, which are zero while idle.
    main u_core (
        .B  (op_b_q),
        .A  (op_a_q),
        .PO (core_po)
    );

    assign acc_a   = req_a[grant_idx*W +: W];
    assign acc_b   = req_b[grant_idx*W +: W];
    assign accept  = (state_q == IDLE) && any && !rst;
    assign zero_op = (acc_a == '0) || (acc_b == '0);

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MUL_ZERO_SKIP_EN
                    state_d = zero_op ? HOLD : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    state_d = HOLD;
            HOLD:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d = grant_idx;
                    id_d     = grant_idx;
                    op_a_d   = acc_a;
                    op_b_d   = acc_b;
`ifdef MUL_ZERO_SKIP_EN
                    if (zero_op) begin
                        op_a_d      = '0;
                        op_b_d      = '0;
                        rsp_data_d  = '0;
                        rsp_id_d    = grant_idx;
                        rsp_valid_d = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                rsp_data_d  = core_po;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                op_a_d      = '0;
                op_b_d      = '0;
            end
            HOLD: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Outputs: req_ready is the only combinational path from req_valid.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && !rst) begin
            req_ready = grant;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb (NREQ=4).
module tb_mul_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned PW   = 20;
    localparam int unsigned IDW  = 2;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PW-1:0]     rsp_data;
    logic [IDW-1:0]    rsp_id;

    int total = 0;
    int bad   = 0;

    int rr_prod [4] = '{200, 253, 312, 377};

    mul_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    // Issue a request pattern, expect grant exp_id, then drain one response.
    task automatic run_one(input string tag, input logic [3:0] v, input int exp_id,
                           input int exp_data, input int lat, input bit hold);
        req_valid = v;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << exp_id);
        tick();
        if (!hold) req_valid = '0;
        if (lat == 2) begin
            chk({tag, "_calc_valid"}, 32'(rsp_valid), 0);
            chk({tag, "_calc_ready"}, 32'(req_ready), 0);
            tick();
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, "_hold_ready"}, 32'(req_ready), 0);
        chk({tag, "_hold_opa"}, 32'(dut.op_a_q), 0);
        chk({tag, "_hold_opb"}, 32'(dut.op_b_q), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_opa", 32'(dut.op_a_q), 0);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request from requester 0
        set_ops(0, 13, 11);
        chk("idle_opa", 32'(dut.op_a_q), 0);
        run_one("single", 4'b0001, 0, 143, 2, 1'b0);

        // Maximum operands from requester 3
        set_ops(3, 255, 255);
        run_one("max", 4'b1000, 3, 65025, 2, 1'b0);

        // Round robin with all requesters valid; pointer is at 3
        for (int i = 0; i < 4; i++) set_ops(i, 10 + i, 20 + 3 * i);
        for (int k = 0; k < 5; k++) begin
            run_one($sformatf("rr%0d", k), 4'b1111, k % 4, rr_prod[k % 4], 2, 1'b1);
        end
        req_valid = '0;

        // Backpressure on requester 2 while others wait
        set_ops(2, 100, 7);
        req_valid = 4'b0100;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 1);
            chk($sformatf("bp_data%0d", c), 32'(rsp_data), 700);
            chk($sformatf("bp_id%0d", c), 32'(rsp_id), 2);
            chk($sformatf("bp_rdy%0d", c), 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", 32'(req_ready), 0);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("bp_resume_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("bp_next_data", 32'(rsp_data), 377);
        chk("bp_next_id", 32'(rsp_id), 3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while requester 1 is in CALC
        req_valid = 4'b0010;
        #1;
        chk("mid_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mid_stale%0d", c), 32'(rsp_valid), 0);
            tick();
        end
        run_one("mid_rr", 4'b1111, 0, 200, 2, 1'b0);

        // Zero operand from requester 1
        set_ops(1, 0, 200);
        chk("zero_idle_opa", 32'(dut.op_a_q), 0);
        chk("zero_idle_opb", 32'(dut.op_b_q), 0);
        run_one("zero", 4'b0010, 1, 0, ZLAT, 1'b0);

        // Nonzero after zero still takes the full path
        set_ops(2, 3, 5);
        run_one("post_zero", 4'b0100, 2, 15, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
